// File: rtl/fetch_controller_pkg.sv
// ---------------------------------------------------------------------------
// fetch_controller_pkg
// Shared types and constants for the instruction fetch sequencer.
//   fetch_state_t   : sequencer state (IDLE / RUN)
//   CODE_ADDR_WIDTH : code memory address width, also the PC width
//   INSTR_WIDTH     : instruction word width
//   RETIRED_MAX     : saturation value of the retired-instruction counter
// ---------------------------------------------------------------------------
package fetch_controller_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    localparam int CODE_ADDR_WIDTH = 9;
    localparam int INSTR_WIDTH     = 16;

    localparam logic [15:0] RETIRED_MAX = 16'hFFFF;

endpackage

// File: rtl/fetch_controller.sv
// ---------------------------------------------------------------------------
// fetch_controller
// Drives the address of a synchronous-read code memory (data appears one
// clock after the address) and presents fetched words to the decoder over a
// valid/ready handshake. Sequential flow and jumps run without bubbles.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   in_start        : leave IDLE and fetch from in_start_addr
//   in_start_addr   : first fetch address
//   in_halt         : stop fetching (RUN only)
//   in_jump         : redirect fetch to in_jump_addr (RUN only)
//   in_jump_addr    : jump target
//   in_ready        : decoder accepts out_instr this cycle
//   out_mem_addr    : combinational address to code memory
//   in_mem_data     : registered read data from code memory
//   out_valid       : out_instr / out_pc hold a fetched instruction
//   out_instr       : fetched instruction (0 when not valid)
//   out_pc          : address of out_instr
//   out_running     : sequencer is in RUN
//   out_retired     : accepted-instruction count, saturating
// ---------------------------------------------------------------------------
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int ADDR_WIDTH = CODE_ADDR_WIDTH,
    parameter int DATA_WIDTH = INSTR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_start,
    input  logic [ADDR_WIDTH-1:0] in_start_addr,
    input  logic                  in_halt,
    input  logic                  in_jump,
    input  logic [ADDR_WIDTH-1:0] in_jump_addr,
    input  logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] out_mem_addr,
    input  logic [DATA_WIDTH-1:0] in_mem_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  out_running,
    output logic [15:0]           out_retired
);

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  valid_q, valid_d;
    logic [15:0]           retired_q, retired_d;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic                  accept;

    assign accept = valid_q && in_ready;
    // Natural ADDR_WIDTH-bit overflow gives the wrap from the last word to 0.
    assign pc_inc = pc_q + PC_ONE;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        valid_d      = valid_q;
        retired_d    = retired_q;
        out_mem_addr = pc_q;

        case (state_q)
            IDLE: begin
                // Present the start address early so its word is ready the
                // cycle after in_start.
                out_mem_addr = in_start_addr;
                if (in_start) begin
                    pc_d    = in_start_addr;
                    valid_d = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (in_halt) begin
                    state_d      = IDLE;
                    valid_d      = 1'b0;
                    out_mem_addr = pc_q;
                end else if (in_jump) begin
                    // Unaccepted current word is simply dropped: the target
                    // word replaces it next cycle.
                    out_mem_addr = in_jump_addr;
                    pc_d         = in_jump_addr;
                end else if (accept) begin
                    out_mem_addr = pc_inc;
                    pc_d         = pc_inc;
                end else begin
                    // Stall: re-read the same word so out_instr stays stable.
                    out_mem_addr = pc_q;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        // An accept counts even when a halt or jump shares the cycle.
        if (accept && (retired_q != RETIRED_MAX)) begin
            retired_d = retired_q + 16'd1;
        end

        if (reset) begin
            out_mem_addr = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            valid_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            retired_q <= retired_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = pc_q;
    assign out_instr   = valid_q ? in_mem_data : '0;
    assign out_running = (state_q == RUN);
    assign out_retired = retired_q;

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequencer for the synchronous-read `code_memory` (9-bit address, 16-bit word, data registered one clock after the address is presented). It drives the memory address every cycle and maintains the program counter. It presents fetched instructions to the decoder over a valid/ready handshake, and handles start, halt, jump redirect and back-pressure without extra bubbles. It sits between `code_memory` and the decode stage; the memory is instantiated beside it, not inside it.

## Interface
- `ADDR_WIDTH`, 9: code memory address width; PC width.
- `DATA_WIDTH`, 16: instruction width.
- `clk`  input  1  single clock, all state updates on rising edge.
- `reset`  input  1  synchronous, active-high.
- `in_start`  input  1  leave IDLE and begin fetching at `in_start_addr`; ignored in RUN.
- `in_start_addr`  input  ADDR_WIDTH  first fetch address.
- `in_halt`  input  1  stop fetching; ignored in IDLE.
- `in_jump`  input  1  redirect fetch to `in_jump_addr` (RUN only).
- `in_jump_addr`  input  ADDR_WIDTH  jump target.
- `in_ready`  input  1  decoder accepts `out_instr` this cycle.
- `out_mem_addr`  output  ADDR_WIDTH  address to `code_memory.in_addr`; combinational.
- `in_mem_data`  input  DATA_WIDTH  from `code_memory.out_data`.
- `out_valid`  output  1  `out_instr` and `out_pc` hold a fetched instruction.
- `out_instr`  output  DATA_WIDTH  `in_mem_data` when `out_valid`, else 0.
- `out_pc`  output  ADDR_WIDTH  address of `out_instr`.
- `out_running`  output  1  state == RUN.
- `out_retired`  output  16  count of accepted instructions; saturates at 0xFFFF.

## Operation
- States: IDLE, RUN. Registers: `state`, `pc`, `valid`, `retired`.
- `out_valid = valid`; `out_pc = pc`. An accept is `out_valid && in_ready`.
- **IDLE:**
  - `out_mem_addr = in_start_addr`.
  - On `in_start`: `pc <= in_start_addr`, `valid <= 1`, `state <= RUN`.
- **RUN:** `out_mem_addr` is chosen by priority, highest first.
  1. `in_halt`: `state <= IDLE`, `valid <= 0`, `out_mem_addr = pc`. An accept in the same cycle still counts.
  2. `in_jump`: `out_mem_addr = in_jump_addr`, `pc <= in_jump_addr`. The current instruction is consumed if accepted in the same cycle, otherwise discarded.
  3. Accept: `out_mem_addr = pc + 1` modulo 2^ADDR_WIDTH, so 511 wraps to 0, and `pc` takes that value.
  4. Otherwise (stall): `out_mem_addr = pc`. The memory re-reads the same word, so `out_instr` stays stable; `pc` is unchanged.
- `retired` increments on every accept unless it equals 0xFFFF.
- `in_start` in RUN, and `in_halt`/`in_jump` in IDLE, have no effect.

## Timing
- **Reset:**
  - While `reset` is high, `out_mem_addr = 0`.
  - The following cycle: state IDLE, `pc = 0`, `valid = 0`, `retired = 0`, `out_instr = 0`, `out_running = 0`.
  - Reset mid-RUN discards the in-flight instruction; no accept is counted in the reset cycle.
- **Start latency:** `in_start` in cycle n gives `out_valid = 1`, `out_instr = mem[in_start_addr]` in cycle n+1.
- **Throughput:** one instruction per cycle while `in_ready` stays high. There is no bubble on sequential flow or on a jump: the target instruction is valid the cycle after `in_jump`.
- **Halt:** `in_halt` in cycle n gives `out_valid = 0` in cycle n+1.
- **Handshake:** while `out_valid && !in_ready`, `out_instr` and `out_pc` are held stable.

## Structure
- Shared package holds:
  - the `fetch_state_t` enum {IDLE, RUN};
  - `CODE_ADDR_WIDTH = 9`, `INSTR_WIDTH = 16`;
  - `RETIRED_MAX = 16'hFFFF`.
- No sub-module: a next-address mux plus three registers.
- `code_memory` is instantiated alongside this block by the integrating top and by the bench.

## Test plan
Bench memory contents: mem[0] = 0xF0F0, mem[1] = 0x0F0F.
- **Reset then start:** reset, then `in_start` with addr 0 and `in_ready = 1`.
  - Cycle +1: `out_valid = 1`, `out_instr = 0xF0F0`, `out_pc = 0`.
  - Cycle +2: `out_instr = 0x0F0F`, `out_pc = 1`.
- **Stall:** start at 0, `in_ready = 0` for 3 cycles.
  - `out_instr` holds 0xF0F0 and `out_mem_addr = 0` each cycle.
  - Raising `in_ready` gives `out_pc = 1` next cycle; `out_retired = 1`.
- **Jump:** in RUN at pc 0, `in_jump` with addr 1 and `in_ready = 0`.
  - Next cycle: `out_pc = 1`, `out_instr = 0x0F0F`.
  - `out_retired` is unchanged (instruction discarded).
- **Wrap:** start at 511 with `in_ready = 1`.
  - Cycle +1: `out_pc = 511`.
  - Cycle +2: `out_pc = 0`, `out_instr = 0xF0F0`.
- **Halt vs jump:** `in_halt` and `in_jump` in the same cycle.
  - Next cycle: `out_valid = 0`, `out_running = 0`, `out_pc` unchanged.
  - A later `in_start` with addr 1 resumes with 0x0F0F.
- **Reset mid-RUN:** reset asserted while `out_valid = 1`.
  - Next cycle: `out_valid = 0`, `out_retired = 0`, `out_mem_addr = 0`, `out_pc = 0`.
